wave_channel_banked: RTL
========================

// Module: wave_channel_banked
// PURPOSE
//  Second-generation GBA sound channel 3: a wave-RAM playback channel with two banks of SAMPLES_PER_BANK samples each.
//  Adds bank select, 2-bank (64-sample) dimension mode, trigger/enable control, length counter, and a corrected
//  volume path (incl. forced 75%). Instantiated by the sound mixer alongside the square/noise channels.
//  Registered sample is fed to the mixer.
// PARAMETERS
//  SAMPLE_W        4   bits per wave sample
//  SAMPLES_PER_BANK 32 samples per bank (2 banks fixed); halfwords/bank HW_PER_BANK = SAMPLES_PER_BANK*SAMPLE_W/16
//  TICK_MULT       4   system_clock cycles per frequency unit; period = (2048-freq)*TICK_MULT
//  LEN_W           9   length counter width (max load 256)
// PORTS
//  system_clock  in   1   sole clock, all state on rising edge
//  reset         in   1   synchronous, active-low
//  NR30          in   8   [7] DAC enable, [6] play bank select, [5] dimension (1 = 64 samples)
//  NR31          in   8   length load; counter <= 256 - NR31
//  nr31_wr       in   1   1-cycle strobe: NR31 was written
//  NR32          in   8   [7] force 75%, [6:5] volume code
//  NR33          in   8   frequency[7:0]
//  NR34          in   8   [7] trigger, [6] length enable, [2:0] frequency[10:8]
//  nr34_wr       in   1   1-cycle strobe: NR34 was written (trigger = nr34_wr & NR34[7])
//  len_tick      in   1   1-cycle 256 Hz strobe from frame sequencer
//  wr_en         in   1   CPU wave-RAM halfword write
//  wr_addr       in   $clog2(HW_PER_BANK)  halfword index within the non-playing bank
//  wr_data       in   16  halfword data
//  wave          out  SAMPLE_W  volume-scaled sample, registered
//  active        out  1   channel playing
// BEHAVIOUR
//  Reset (reset==0 at edge): wave=0, active=0, pos=0, timer=0, length=0, RAM contents unchanged.
//  Sample order: sample i of a bank = byte i/2 of the bank (halfword low byte first), high nibble if i even.
//  CPU writes always target bank !NR30[6] (in either dimension); data is visible to playback the next cycle.
//  Trigger: if NR30[7] then active<=1; pos<=0 (sample 0 of bank NR30[6]); timer<=period-1.
//    If length==0 the counter is loaded with 256. Trigger with NR30[7]=0: active stays 0, reloads still occur.
//  NR30[7]==0 at any edge: active<=0 next cycle (overrides trigger).
//  Timer: while active, decrements every cycle; at 0 reloads period-1 and advances pos.
//    freq=2047 gives a new sample every 4 cycles.
//  pos: 5 bits (dim=0) wraps 31->0 in the selected bank. dim=1: 6-bit index, starting at the selected bank,
//    crosses to the other bank at 32, wraps 63->0. Bank/dimension changes take effect at the next pos advance.
//  Length: nr31_wr loads 256-NR31. On len_tick with NR34[6]=1 and length!=0: decrement; reaching 0 -> active<=0.
//  Priority, same cycle: reset > trigger > nr31_wr > len_tick (no decrement in a cycle with a trigger or load).
//  Volume, s = current sample: NR32[7]=1 -> (s*3)>>2; else 00 -> 0, 01 -> s, 10 -> s>>1, 11 -> s>>2.
//  wave is registered: it reflects pos/volume one cycle after they change. wave=0 whenever active=0.
//  Inactive: timer and pos hold; length may still be loaded.
// TESTING
//  Reset: reset=0 for 2 cycles mid-playback -> wave=0, active=0 next edge; after release, no output until trigger.
//  Playback: NR30[6]=0 so writes go to bank1; write hw0=0x2301, hw1=0x6745; then NR30=0xC0, NR32=0x20, freq=2047,
//    trigger -> wave steps 0,1,2,3,4,5,6,7, 4 cycles per step.
//  Volume: all samples 0xF -> NR32 0x00/0x20/0x40/0x60/0x80 give wave 0/15/7/3/11.
//  Dimension: bank0 all 0x1, bank1 all 0x2, NR30=0xA0 -> 32 samples of 1, then 32 of 2, then wraps back to 1.
//    With NR30[5]=0, only 1s are played.
//  Length: NR31=254 & nr31_wr, NR34[6]=1, trigger; 2 len_ticks -> active=0 after the 2nd;
//    len_tick coincident with a trigger -> no decrement.
//  Disable: NR30[7]->0 while playing -> active=0 and wave=0 by the 2nd edge; trigger while disabled -> active stays 0.

Source files
------------

// File: rtl/wave_channel_banked.sv
// wave_channel_banked: banked wave-RAM playback channel (GBA sound channel 3) for the sound mixer.
// Latency: wave is registered, one cycle behind pos/volume changes; RAM writes are visible next cycle.
// Backpressure: none; register strobes, len_tick and RAM writes are single-cycle and always accepted.
// Ports: system_clock / reset (synchronous, active-low); NR30..NR34 register contents with the
//   nr31_wr / nr34_wr write strobes; len_tick 256 Hz frame-sequencer strobe; wr_en / wr_addr / wr_data
//   CPU halfword write into the bank not selected for playback; wave scaled sample; active playing flag.
module wave_channel_banked #(
  parameter int SAMPLE_W         = 4,
  parameter int SAMPLES_PER_BANK = 32,
  parameter int TICK_MULT        = 4,
  parameter int LEN_W            = 9,
  localparam int HW_PER_BANK     = SAMPLES_PER_BANK * SAMPLE_W / 16,
  localparam int AW              = $clog2(HW_PER_BANK)
) (
  input  logic                system_clock,
  input  logic                reset,
  input  logic [7:0]          NR30,
  input  logic [7:0]          NR31,
  input  logic                nr31_wr,
  input  logic [7:0]          NR32,
  input  logic [7:0]          NR33,
  input  logic [7:0]          NR34,
  input  logic                nr34_wr,
  input  logic                len_tick,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [15:0]         wr_data,
  output logic [SAMPLE_W-1:0] wave,
  output logic                active
);
  localparam int IW = $clog2(SAMPLES_PER_BANK);   // sample index within one bank
  localparam int TW = $clog2(2048 * TICK_MULT + 1);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(256);

  // Both banks in one array; the top address bit is the bank number.
  logic [15:0]         ram [2*HW_PER_BANK];

  logic [IW:0]         pos;        // bit IW only used in 64-sample mode
  logic [TW-1:0]       timer;
  logic [LEN_W-1:0]    length;
  logic                play_bank;  // bank/dim latched at trigger and each advance
  logic                dim;

  logic                trigger;
  logic                len_expire;
  logic                active_nxt;
  logic [11:0]         steps;
  logic [TW-1:0]       period_m1;
  logic [IW:0]         pos_adv;
  logic                rd_bank;
  logic [15:0]         rd_hw;
  logic [7:0]          rd_byte;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W+1:0] sample_x3;
  logic [SAMPLE_W-1:0] scaled;
  logic                unused_bits;

  assign unused_bits = ^{NR30[4:0], NR32[4:0], NR34[5:3]};

  assign trigger   = nr34_wr & NR34[7];
  assign steps     = 12'd2048 - {1'b0, NR34[2:0], NR33};
  assign period_m1 = TW'(steps) * TW'(TICK_MULT) - TW'(1);

  // The dimension that becomes current at this advance decides whether pos
  // runs across both banks or wraps inside one.
  assign pos_adv = NR30[5] ? pos + 1'b1 : {1'b0, pos[IW-1:0] + 1'b1};

  // Sample i: byte i/2 of the bank (low byte of each halfword first), high nibble for even i.
  assign rd_bank   = play_bank ^ (dim & pos[IW]);
  assign rd_hw     = ram[{rd_bank, pos[IW-1:2]}];
  assign rd_byte   = pos[1] ? rd_hw[15:8] : rd_hw[7:0];
  assign sample    = pos[0] ? rd_byte[SAMPLE_W-1:0] : rd_byte[2*SAMPLE_W-1:SAMPLE_W];
  assign sample_x3 = {2'b00, sample} + {1'b0, sample, 1'b0};

  always_comb begin
    scaled = '0;
    if (NR32[7]) begin
      scaled = sample_x3[SAMPLE_W+1:2];
    end else begin
      case (NR32[6:5])
        2'b01:   scaled = sample;
        2'b10:   scaled = sample >> 1;
        2'b11:   scaled = sample >> 2;
        default: scaled = '0;
      endcase
    end
  end

  // Expiry only when a tick really decrements: trigger and length load both win over it.
  assign len_expire = len_tick & NR34[6] & (length == LEN_W'(1)) & ~trigger & ~nr31_wr;

  always_comb begin
    active_nxt = active;
    if (!NR30[7])        active_nxt = 1'b0;
    else if (trigger)    active_nxt = 1'b1;
    else if (len_expire) active_nxt = 1'b0;
  end

  // Wave RAM keeps its contents through reset.
  always_ff @(posedge system_clock) begin
    if (wr_en) ram[{~NR30[6], wr_addr}] <= wr_data;
  end

  always_ff @(posedge system_clock) begin
    if (!reset) begin
      active    <= 1'b0;
      wave      <= '0;
      pos       <= '0;
      timer     <= '0;
      length    <= '0;
      play_bank <= 1'b0;
      dim       <= 1'b0;
    end else begin
      active <= active_nxt;
      // Silent on the trigger edge too, so a stale sample never leaks out.
      wave   <= (active & active_nxt) ? scaled : '0;

      if (trigger) begin
        pos       <= '0;
        timer     <= period_m1;
        play_bank <= NR30[6];
        dim       <= NR30[5];
      end else if (active) begin
        if (timer == '0) begin
          timer     <= period_m1;
          pos       <= pos_adv;
          play_bank <= NR30[6];
          dim       <= NR30[5];
        end else begin
          timer <= timer - 1'b1;
        end
      end

      if (trigger) begin
        if (length == '0) length <= LEN_FULL;
      end else if (nr31_wr) begin
        length <= LEN_FULL - LEN_W'(NR31);
      end else if (len_tick && NR34[6] && length != '0) begin
        length <= length - 1'b1;
      end
    end
  end
endmodule
